// File: rtl/cmd_responder_pkg.sv
// cmd_responder_pkg: shared FSM states, response byte defaults and opcode limit
package cmd_responder_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_EXEC, SEND_RESP, WAIT_TX} state_t;
  localparam logic [7:0] ACK_DEF = 8'hA5;
  localparam logic [7:0] NAK_DEF = 8'hEE;
  localparam logic [3:0] OPC_MAX = 4'h7;
  function automatic logic opc_ok(input logic [3:0] opc);
    return opc <= OPC_MAX;
  endfunction
endpackage

// File: rtl/cmd_responder_resp_timeout.sv
// resp_timeout: execution watchdog that holds at its last count instead of wrapping
module resp_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);
  logic [W-1:0] cnt;
  assign expire = en && cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != LAST) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cmd_responder.sv
// cmd_responder: accepts UART commands, hands valid ones to an executor and sends back ACK/NAK
module cmd_responder
  import cmd_responder_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] ACK         = ACK_DEF,
  parameter logic [7:0] NAK         = NAK_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_rdy,
  input  logic [15:0] cmd,
  output logic        clr_cmd_rdy,
  output logic        trmt,
  output logic [7:0]  resp,
  input  logic        tx_done,
  output logic        cmd_vld,
  output logic [15:0] cmd_out,
  input  logic        cmd_done,
  input  logic        cmd_err,
  output logic        busy,
  output logic [7:0]  nak_cnt
);
  state_t state, state_nx;
  logic [7:0] resp_nx;
  logic expire;
  assign busy = state != IDLE;
  assign cmd_vld = state == WAIT_EXEC;
  assign trmt = state == SEND_RESP;
  // gated by rst_n so a pending command is not consumed while held in reset
  assign clr_cmd_rdy = rst_n && state == IDLE && cmd_rdy;
  resp_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk,
    .rst_n,
    .clr(!cmd_vld),
    .en(cmd_vld),
    .expire
  );
  always_comb begin
    state_nx = state;
    resp_nx = resp;
    case (state)
      IDLE: if (cmd_rdy) begin
        state_nx = opc_ok(cmd[15:12]) ? WAIT_EXEC : SEND_RESP;
        resp_nx = opc_ok(cmd[15:12]) ? resp : NAK;
      end
      WAIT_EXEC: if (cmd_done || expire) begin
        state_nx = SEND_RESP;
        resp_nx = cmd_done && !cmd_err ? ACK : NAK;
      end
      SEND_RESP: state_nx = WAIT_TX;
      WAIT_TX: state_nx = tx_done ? IDLE : WAIT_TX;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      resp <= 8'h00;
      cmd_out <= 16'h0000;
      nak_cnt <= 8'h00;
    end else begin
      state <= state_nx;
      resp <= resp_nx;
      if (clr_cmd_rdy) cmd_out <= cmd;
      if (state == WAIT_TX && tx_done && resp == NAK && nak_cnt != 8'hFF) nak_cnt <= nak_cnt + 8'd1;
    end
endmodule

// File: tb/tb_cmd_responder.sv
// tb_cmd_responder: randomized scoreboard bench for cmd_responder against a transaction-level model
module tb_cmd_responder;
  localparam int TMO = 16;
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;
  logic clk = 0, rst_n = 0;
  logic cmd_rdy = 0, tx_done = 0, cmd_done = 0, cmd_err = 0;
  logic [15:0] cmd = 0;
  logic clr_cmd_rdy, trmt, cmd_vld, busy;
  logic [7:0] resp, nak_cnt;
  logic [15:0] cmd_out;
  int n_chk = 0, n_fail = 0, exp_nak = 0;
  bit tx_hold = 0, noise = 0;
  logic txd_s = 0;
  logic [7:0] resp_q[$];
  logic [15:0] cmd_q[$];
  int len_q[$], exd_q[$];
  bit exe_q[$];

  cmd_responder #(.TIMEOUT_CYC(TMO), .ACK(ACK), .NAK(NAK)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .clr_cmd_rdy(clr_cmd_rdy),
    .trmt(trmt), .resp(resp), .tx_done(tx_done), .cmd_vld(cmd_vld), .cmd_out(cmd_out),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .busy(busy), .nak_cnt(nak_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) txd_s <= tx_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // executor: finishes a command on its d-th cmd_vld cycle; d >= TMO never finishes
  initial begin
    int k = 0, ed = 0;
    bit ee = 0;
    forever begin
      @(negedge clk);
      cmd_done = 0;
      cmd_err = 0;
      if (cmd_vld) begin
        if (k == 0) begin
          if (exd_q.size() == 0) chk("exec_queue", 0, 1);
          else begin ed = exd_q.pop_front(); ee = exe_q.pop_front(); end
        end
        if (k == ed) begin cmd_done = 1; cmd_err = ee; end
        k++;
      end else begin
        k = 0;
        if (noise && $urandom_range(7) == 0) begin cmd_done = 1; cmd_err = 1'($urandom); end
      end
    end
  end

  // transmitter: random shift-out delay after each trmt
  initial forever begin
    @(negedge clk);
    if (trmt) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      if (!tx_hold) begin
        tx_done = 1;
        @(negedge clk);
        tx_done = 0;
      end
    end
  end

  // monitor: response byte, its stability, latched command and cmd_vld duration
  initial begin
    int vk = 0;
    logic [7:0] held = 0;
    forever begin
      @(negedge clk);
      if (trmt) begin
        held = resp;
        if (resp_q.size() == 0) chk("resp_queue", 0, 1);
        else chk("resp", resp, resp_q.pop_front());
      end else if (busy && !cmd_vld) chk("resp_stable", resp, held);
      if (cmd_vld) begin
        if (vk == 0) begin
          if (cmd_q.size() == 0) chk("cmd_queue", 0, 1);
          else chk("cmd_out", cmd_out, cmd_q.pop_front());
        end
        vk++;
      end else if (vk > 0) begin
        if (len_q.size() == 0) chk("len_queue", 0, 1);
        else chk("vld_cycles", vk, len_q.pop_front());
        vk = 0;
      end
    end
  end

  task automatic model(input logic [15:0] c, input int d, input bit e);
    logic [7:0] r;
    if (c[15:12] <= 4'h7) begin
      exd_q.push_back(d);
      exe_q.push_back(e);
      cmd_q.push_back(c);
      len_q.push_back(d < TMO ? d + 1 : TMO);
      r = (d < TMO && !e) ? ACK : NAK;
    end else r = NAK;
    resp_q.push_back(r);
    if (r == NAK && exp_nak < 255) exp_nak++;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 200);
    chk("idle_timeout", busy, 0);
    chk("nak_cnt", nak_cnt, exp_nak[7:0]);
  endtask

  task automatic issue(input logic [15:0] c, input int d, input bit e, input bit b2b);
    int n = 0;
    bit bp, v;
    if (!b2b) wait_idle();
    bp = busy;
    v = c[15:12] <= 4'h7;
    model(c, d, e);
    cmd = c;
    cmd_rdy = 1;
    #1;
    while (!clr_cmd_rdy && n < 200) begin @(negedge clk); n++; end
    chk("clr_timeout", clr_cmd_rdy, 1);
    if (bp) chk("clr_after_tx_done", txd_s, 1);
    @(posedge clk);
    #1;
    cmd_rdy = 0;
    cmd = 16'($urandom);
    @(negedge clk);
    chk("vld_after_accept", cmd_vld, v);
    chk("trmt_after_accept", trmt, !v);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_clr", clr_cmd_rdy, 0);
    chk("rst_trmt", trmt, 0);
    chk("rst_resp", resp, 0);
    chk("rst_vld", cmd_vld, 0);
    chk("rst_cmd_out", cmd_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nak", nak_cnt, 0);
    rst_n = 1;
    issue(16'h1234, 9, 0, 0);
    wait_idle();
    issue(16'h9ABC, 0, 0, 0);
    wait_idle();
    issue(16'h2000, 99, 0, 0);
    issue(16'h3111, 15, 0, 0);
    issue(16'h4222, 15, 1, 0);
    issue(16'h5333, 14, 0, 0);
    issue(16'h6444, 0, 0, 0);
    issue(16'h9000, 0, 0, 0);
    issue(16'hA000, 0, 0, 1);
    issue(16'h7555, 3, 0, 1);
    noise = 1;
    for (int i = 0; i < 60; i++)
      issue(16'($urandom), $urandom_range(0, 20), 1'($urandom), 1'($urandom));
    noise = 0;
    for (int i = 0; i < 260; i++) issue({4'h8 | 4'($urandom), 12'($urandom)}, 0, 0, 1);
    wait_idle();
    chk("nak_sat", nak_cnt, 8'hFF);
    tx_hold = 1;
    issue(16'h9ABC, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 0;
    exp_nak = 0;
    cmd = 16'h1234;
    cmd_rdy = 1;
    @(negedge clk);
    chk("mid_rst_clr", clr_cmd_rdy, 0);
    chk("mid_rst_trmt", trmt, 0);
    chk("mid_rst_resp", resp, 0);
    chk("mid_rst_vld", cmd_vld, 0);
    chk("mid_rst_cmd_out", cmd_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_nak", nak_cnt, 0);
    repeat (8) @(negedge clk);
    tx_hold = 0;
    model(16'h1234, 9, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    cmd_rdy = 0;
    @(negedge clk);
    chk("post_rst_vld", cmd_vld, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("resp_q_empty", resp_q.size(), 0);
    chk("len_q_empty", len_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
